// File: rtl/coeff_seq_loader_pkg.sv
//==============================================================================
// Package     : coeff_loader_pkg
// Description : Shared types and default constants for the coefficient
//               sequencer: the FSM state encoding and the default set size
//               and watchdog timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package coeff_loader_pkg;

    // Default number of coefficients per set.
    localparam int unsigned c_DEFAULT_NUM_COEFF      = 4;

    // Default watchdog limit on consecutive modwait-high cycles in HOLD.
    localparam int unsigned c_DEFAULT_TIMEOUT_CYCLES = 255;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage : coeff_loader_pkg

`default_nettype wire

// File: rtl/coeff_seq_loader_if.sv
//==============================================================================
// Interface   : coeff_seq_loader_if
// Description : Handshake bundle between the AHB-Lite slave / FIR core and the
//               coefficient sequencer. The master modport is the sequencer
//               side; the slave modport is the AHB slave / FIR core side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface coeff_seq_loader_if
    import coeff_loader_pkg::*;
#(
    parameter int unsigned IDX_W = $clog2(c_DEFAULT_NUM_COEFF)
);

    logic             new_coefficient_set;
    logic             modwait;
    logic             load_coeff;
    logic [IDX_W-1:0] coefficient_num;
    logic             clear_new_coefficient;
    logic             busy;
    logic             load_error;

    modport master (
        input  new_coefficient_set,
        input  modwait,
        output load_coeff,
        output coefficient_num,
        output clear_new_coefficient,
        output busy,
        output load_error
    );

    modport slave (
        output new_coefficient_set,
        output modwait,
        input  load_coeff,
        input  coefficient_num,
        input  clear_new_coefficient,
        input  busy,
        input  load_error
    );

endinterface : coeff_seq_loader_if

`default_nettype wire

// File: rtl/coeff_seq_loader_wait_timer.sv
//==============================================================================
// Module      : coeff_wait_timer
// Description : Clear-on-low saturating counter. Counts cycles in which both
//               i_arm and i_level are high and clears whenever either is low.
//               o_terminal flags the cycle that would be the LIMIT-th
//               consecutive counted cycle, so the caller can act on it at the
//               same clock edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module coeff_wait_timer #(
    parameter  int unsigned LIMIT = 255,
    localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  wire logic clk,
    input  wire logic n_reset,
    input  wire logic i_arm,
    input  wire logic i_level,
    output logic      o_terminal
);

    localparam logic [CNT_W-1:0] c_SAT  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LIMIT - 1);

    logic             w_count_en;
    logic [CNT_W-1:0] r_count;

    assign w_count_en = i_arm & i_level;

    // Count consecutive qualified cycles, clearing on any gap, saturating at LIMIT.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count <= '0;
        end else if (!w_count_en) begin
            r_count <= '0;
        end else if (r_count != c_SAT) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // The current qualified cycle is the LIMIT-th when LIMIT-1 were already seen.
    assign o_terminal = w_count_en & (r_count >= c_LAST);

endmodule : coeff_wait_timer

`default_nettype wire

// File: rtl/coeff_seq_loader.sv
//==============================================================================
// Module      : coeff_seq_loader
// Description : Transfers a full set of NUM_COEFF coefficients from the AHB
//               slave register file into the FIR core, one coefficient per
//               ISSUE/SETTLE/HOLD handshake, then strobes
//               clear_new_coefficient. Outputs are decoded from registered
//               state only.
//               Optional feature macro: COEFF_SEQ_LOADER_WATCHDOG_EN
//               (stuck-filter watchdog that aborts HOLD after TIMEOUT_CYCLES
//               consecutive modwait-high cycles and raises load_error).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module coeff_seq_loader
    import coeff_loader_pkg::*;
#(
    parameter  int unsigned NUM_COEFF      = c_DEFAULT_NUM_COEFF,
    parameter  int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned IDX_W          = $clog2(NUM_COEFF)
) (
    input  wire logic          clk,
    input  wire logic          n_reset,
    coeff_seq_loader_if.master bus
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_COEFF - 1);

    // Reject out-of-range configurations at elaboration.
    if (NUM_COEFF < 2 || NUM_COEFF > 16) begin : g_bad_num_coeff
        $error("coeff_seq_loader: NUM_COEFF must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("coeff_seq_loader: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_next;
    logic             w_timeout;
    logic             w_in_hold;
    logic             w_load_coeff;
    logic             w_clear;
    logic             w_busy;
    logic [IDX_W-1:0] w_coeff_num;

    assign w_in_hold = (r_state == HOLD);

    // State and coefficient index registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
        end
    end

    // Next-state, index advance and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_load_coeff = 1'b0;
        w_clear      = 1'b0;
        w_busy       = (r_state != IDLE);
        w_coeff_num  = '0;

        unique case (r_state)
            IDLE: begin
                // A set is only accepted once the FIR core is free.
                if (bus.new_coefficient_set && !bus.modwait) begin
                    w_state_next = ISSUE;
                    w_index_next = '0;
                end
            end
            ISSUE: begin
                w_load_coeff = 1'b1;
                w_coeff_num  = r_index;
                w_state_next = SETTLE;
            end
            SETTLE: begin
                // modwait may not yet reflect the load, so it is not sampled here.
                w_coeff_num  = r_index;
                w_state_next = HOLD;
            end
            HOLD: begin
                w_coeff_num = r_index;
                if (!bus.modwait) begin
                    if (r_index == c_LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_index_next = r_index + IDX_W'(1);
                        w_state_next = ISSUE;
                    end
                end else if (w_timeout) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_clear      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.load_coeff            = w_load_coeff;
    assign bus.clear_new_coefficient = w_clear;
    assign bus.busy                  = w_busy;
    assign bus.coefficient_num       = w_coeff_num;

`ifdef COEFF_SEQ_LOADER_WATCHDOG_EN
    logic r_load_error;

    coeff_wait_timer #(
        .LIMIT      (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_arm      (w_in_hold),
        .i_level    (bus.modwait),
        .o_terminal (w_timeout)
    );

    // Sticky error: set on a watchdog abort, cleared when the next set is accepted.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_load_error <= 1'b0;
        end else if (r_state == IDLE && w_state_next == ISSUE) begin
            r_load_error <= 1'b0;
        end else if (w_in_hold && bus.modwait && w_timeout) begin
            r_load_error <= 1'b1;
        end
    end

    assign bus.load_error = r_load_error;
`else
    // Without the watchdog HOLD waits on the FIR core indefinitely.
    logic w_unused_hold;
    assign w_unused_hold  = w_in_hold;
    assign w_timeout      = 1'b0;
    assign bus.load_error = 1'b0;
`endif

endmodule : coeff_seq_loader

`default_nettype wire

// File: tb/tb_coeff_seq_loader.sv
//==============================================================================
// Module      : tb_coeff_seq_loader
// Description : Directed self-checking bench for coeff_seq_loader with a
//               4-coefficient instance (TIMEOUT_CYCLES = 8) and a
//               16-coefficient instance. Watchdog expectations follow
//               COEFF_SEQ_LOADER_WATCHDOG_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_coeff_seq_loader;

    logic clk     = 1'b0;
    logic n_reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    coeff_seq_loader_if #(.IDX_W(2)) bus4 ();
    coeff_seq_loader_if #(.IDX_W(4)) bus16 ();

    coeff_seq_loader #(.NUM_COEFF(4), .TIMEOUT_CYCLES(8)) dut4 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus4.master)
    );

    coeff_seq_loader #(.NUM_COEFF(16), .TIMEOUT_CYCLES(8)) dut16 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus16.master)
    );

    // Advance one clock; values read afterwards belong to the new cycle and
    // inputs written afterwards are seen at the following edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus4.new_coefficient_set  = 1'b0;
        bus4.modwait              = 1'b0;
        bus16.new_coefficient_set = 1'b0;
        bus16.modwait             = 1'b0;
        n_reset = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({bus4.load_coeff, bus4.clear_new_coefficient, bus4.busy, bus4.load_error} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags4: got %b expected 0000",
                     {bus4.load_coeff, bus4.clear_new_coefficient, bus4.busy, bus4.load_error});
        end
        n_checks++;
        if (bus4.coefficient_num !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_num4: got %0d expected 0", bus4.coefficient_num);
        end
        n_checks++;
        if ({bus16.load_coeff, bus16.clear_new_coefficient, bus16.busy, bus16.load_error, bus16.coefficient_num} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_all16: got %b expected 0",
                     {bus16.load_coeff, bus16.clear_new_coefficient, bus16.busy, bus16.load_error, bus16.coefficient_num});
        end
        @(negedge clk);
        n_reset = 1'b1;
        tick;
        tick;
        n_checks++;
        if (bus4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", bus4.busy);
        end
    endtask

    // Four coefficients, FIR core busy for SETTLE plus two HOLD cycles.
    task automatic test_basic;
        int n_load;
        int n_clear;
        int clear_cyc;
        int mw_left;
        int busy_after;
        int load_cyc[4];
        int load_idx[4];
        logic busy_first;
        logic [1:0] num_hold1;
        logic [1:0] num_done;
        n_load = 0; n_clear = 0; clear_cyc = -1; mw_left = 0; busy_after = 0;
        busy_first = 1'b0; num_hold1 = 2'd0; num_done = 2'd3;
        for (int k = 0; k < 4; k++) begin
            load_cyc[k] = -1;
            load_idx[k] = -1;
        end
        bus4.new_coefficient_set = 1'b1;
        bus4.modwait             = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (c == 1) busy_first = bus4.busy;
            if (c == 8) num_hold1 = bus4.coefficient_num;
            if (c == 21) num_done = bus4.coefficient_num;
            if (c > 21 && bus4.busy) busy_after++;
            if (bus4.load_coeff) begin
                if (n_load < 4) begin
                    load_cyc[n_load] = c;
                    load_idx[n_load] = int'(bus4.coefficient_num);
                end
                n_load++;
                mw_left = 3;
                bus4.modwait = 1'b0;
            end else if (mw_left > 0) begin
                bus4.modwait = 1'b1;
                mw_left--;
            end else begin
                bus4.modwait = 1'b0;
            end
            if (bus4.clear_new_coefficient) begin
                n_clear++;
                clear_cyc = c;
                bus4.new_coefficient_set = 1'b0;
            end
        end
        n_checks++;
        if (n_load !== 4) begin
            n_fail++;
            $display("FAIL basic_load_count: got %0d expected 4", n_load);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (load_idx[k] !== k || load_cyc[k] !== 1 + 5 * k) begin
                n_fail++;
                $display("FAIL basic_load_%0d: got idx %0d at cycle %0d expected idx %0d at cycle %0d",
                         k, load_idx[k], load_cyc[k], k, 1 + 5 * k);
            end
        end
        n_checks++;
        if (n_clear !== 1 || clear_cyc !== 21) begin
            n_fail++;
            $display("FAIL basic_clear: got %0d pulses last at cycle %0d expected 1 at cycle 21", n_clear, clear_cyc);
        end
        n_checks++;
        if (busy_first !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_issue: got %b expected 1", busy_first);
        end
        n_checks++;
        if (num_hold1 !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_num_hold: got %0d expected 1", num_hold1);
        end
        n_checks++;
        if (num_done !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_num_done: got %0d expected 0", num_done);
        end
        n_checks++;
        if (busy_after !== 0) begin
            n_fail++;
            $display("FAIL basic_busy_after: got %0d busy cycles expected 0", busy_after);
        end
    endtask

    // New set pending while the FIR core stays busy in IDLE.
    task automatic test_stalled;
        int bad;
        int n_clear;
        int clear_cyc;
        bad = 0; n_clear = 0; clear_cyc = -1;
        bus4.new_coefficient_set = 1'b1;
        bus4.modwait             = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (bus4.load_coeff || bus4.busy) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_no_issue: got %0d active cycles expected 0", bad);
        end
        bus4.modwait = 1'b0;
        tick;
        n_checks++;
        if (bus4.load_coeff !== 1'b1 || bus4.coefficient_num !== 2'd0) begin
            n_fail++;
            $display("FAIL stall_issue: got load %b idx %0d expected load 1 idx 0",
                     bus4.load_coeff, bus4.coefficient_num);
        end
        for (int c = 12; c <= 30; c++) begin
            tick;
            if (bus4.clear_new_coefficient) begin
                n_clear++;
                clear_cyc = c;
                bus4.new_coefficient_set = 1'b0;
            end
        end
        n_checks++;
        if (n_clear !== 1 || clear_cyc !== 23) begin
            n_fail++;
            $display("FAIL stall_clear: got %0d pulses last at cycle %0d expected 1 at cycle 23", n_clear, clear_cyc);
        end
    endtask

    // Sixteen coefficients with the FIR core never busy.
    task automatic test_sixteen;
        int n_load;
        int order_bad;
        int n_clear;
        int clear_cyc;
        n_load = 0; order_bad = 0; n_clear = 0; clear_cyc = -1;
        bus16.new_coefficient_set = 1'b1;
        bus16.modwait             = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            tick;
            if (bus16.load_coeff) begin
                if (int'(bus16.coefficient_num) !== n_load || c !== 1 + 3 * n_load) order_bad++;
                n_load++;
            end
            if (bus16.clear_new_coefficient) begin
                n_clear++;
                clear_cyc = c;
                bus16.new_coefficient_set = 1'b0;
            end
        end
        n_checks++;
        if (n_load !== 16) begin
            n_fail++;
            $display("FAIL n16_load_count: got %0d expected 16", n_load);
        end
        n_checks++;
        if (order_bad !== 0) begin
            n_fail++;
            $display("FAIL n16_order: got %0d out-of-order pulses expected 0", order_bad);
        end
        n_checks++;
        if (n_clear !== 1 || clear_cyc !== 49) begin
            n_fail++;
            $display("FAIL n16_clear: got %0d pulses last at cycle %0d expected 1 at cycle 49", n_clear, clear_cyc);
        end
        n_checks++;
        if (bus16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL n16_busy_end: got %b expected 0", bus16.busy);
        end
    endtask

    // Asynchronous reset while holding on coefficient 2.
    task automatic test_reset_mid;
        int t;
        int n_clear;
        t = -1; n_clear = 0;
        bus4.new_coefficient_set = 1'b1;
        bus4.modwait             = 1'b0;
        for (int c = 1; c <= 20 && t < 0; c++) begin
            tick;
            if (bus4.load_coeff && bus4.coefficient_num == 2'd2) begin
                t = c;
                bus4.modwait = 1'b1;
            end
        end
        n_checks++;
        if (t !== 7) begin
            n_fail++;
            $display("FAIL rmid_reach_idx2: got cycle %0d expected 7", t);
        end
        tick;
        tick;
        n_checks++;
        if (bus4.busy !== 1'b1 || bus4.coefficient_num !== 2'd2) begin
            n_fail++;
            $display("FAIL rmid_hold: got busy %b idx %0d expected busy 1 idx 2", bus4.busy, bus4.coefficient_num);
        end
        #1;
        n_reset = 1'b0;
        #1;
        n_checks++;
        if ({bus4.load_coeff, bus4.clear_new_coefficient, bus4.busy, bus4.load_error, bus4.coefficient_num} !== 6'd0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got %b expected 000000",
                     {bus4.load_coeff, bus4.clear_new_coefficient, bus4.busy, bus4.load_error, bus4.coefficient_num});
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            if (bus4.clear_new_coefficient) n_clear++;
        end
        bus4.modwait = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        tick;
        n_checks++;
        if (bus4.load_coeff !== 1'b1 || bus4.coefficient_num !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_restart: got load %b idx %0d expected load 1 idx 0",
                     bus4.load_coeff, bus4.coefficient_num);
        end
        for (int c = 0; c < 20; c++) begin
            tick;
            if (bus4.clear_new_coefficient) begin
                n_clear++;
                bus4.new_coefficient_set = 1'b0;
            end
        end
        n_checks++;
        if (n_clear !== 1) begin
            n_fail++;
            $display("FAIL rmid_clear_count: got %0d expected 1", n_clear);
        end
    endtask

    // FIR core stuck busy after coefficient 1 is issued.
    task automatic test_watchdog;
        int t;
        int n_load;
        int n_clear;
        int clear_cyc;
        int err_bad;
        t = -1; n_load = 0; n_clear = 0; clear_cyc = -1; err_bad = 0;
        bus4.new_coefficient_set = 1'b1;
        bus4.modwait             = 1'b0;
        for (int c = 1; c <= 20 && t < 0; c++) begin
            tick;
            if (bus4.load_coeff && bus4.coefficient_num == 2'd1) begin
                t = c;
                bus4.modwait = 1'b1;
            end
        end
        n_checks++;
        if (t !== 4) begin
            n_fail++;
            $display("FAIL wd_reach_idx1: got cycle %0d expected 4", t);
        end
        for (int c = t + 1; c <= t + 30; c++) begin
            tick;
            if (bus4.load_coeff) n_load++;
            if (bus4.clear_new_coefficient) begin
                n_clear++;
                clear_cyc = c;
                bus4.new_coefficient_set = 1'b0;
            end
`ifdef COEFF_SEQ_LOADER_WATCHDOG_EN
            if (c < t + 10 && bus4.load_error !== 1'b0) err_bad++;
            if (c >= t + 10 && bus4.load_error !== 1'b1) err_bad++;
`else
            if (bus4.load_error !== 1'b0) err_bad++;
`endif
        end
        n_checks++;
        if (n_load !== 0) begin
            n_fail++;
            $display("FAIL wd_no_reload: got %0d pulses expected 0", n_load);
        end
        n_checks++;
        if (err_bad !== 0) begin
            n_fail++;
            $display("FAIL wd_error_flag: got %0d wrong cycles expected 0", err_bad);
        end
`ifdef COEFF_SEQ_LOADER_WATCHDOG_EN
        n_checks++;
        if (n_clear !== 1 || clear_cyc !== t + 10) begin
            n_fail++;
            $display("FAIL wd_abort_clear: got %0d pulses last at cycle %0d expected 1 at cycle %0d",
                     n_clear, clear_cyc, t + 10);
        end
        n_checks++;
        if (bus4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_idle_after: got busy %b expected 0", bus4.busy);
        end
        bus4.modwait             = 1'b0;
        bus4.new_coefficient_set = 1'b1;
        tick;
        n_checks++;
        if (bus4.load_coeff !== 1'b1 || bus4.load_error !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_error_clear: got load %b error %b expected load 1 error 0",
                     bus4.load_coeff, bus4.load_error);
        end
        for (int c = 0; c < 20; c++) begin
            tick;
            if (bus4.clear_new_coefficient) bus4.new_coefficient_set = 1'b0;
        end
`else
        n_checks++;
        if (n_clear !== 0) begin
            n_fail++;
            $display("FAIL wd_no_clear: got %0d pulses expected 0", n_clear);
        end
        n_checks++;
        if (bus4.busy !== 1'b1 || bus4.coefficient_num !== 2'd1) begin
            n_fail++;
            $display("FAIL wd_still_hold: got busy %b idx %0d expected busy 1 idx 1",
                     bus4.busy, bus4.coefficient_num);
        end
        bus4.modwait             = 1'b0;
        bus4.new_coefficient_set = 1'b0;
        n_reset = 1'b0;
        tick;
        @(negedge clk);
        n_reset = 1'b1;
        tick;
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stalled;
        test_sixteen;
        test_reset_mid;
        test_watchdog;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_coeff_seq_loader

`default_nettype wire
